seq_pattern_gen: RTL and testbench

- Serial bit-pattern generator; the transmit side for the serial sequence detector.
- Drives a 1-bit serial stream, MSB-first, one bit per clk: a programmable pattern of 1..MAX_LEN bits.
- Repeats the pattern a programmable number of times, with optional idle gaps between repetitions.
- Used as the stimulus source feeding the detector's `in`, and as a standalone pattern source in the design.

---
 rtl/seq_gen_pkg.sv | 18 +
 rtl/seq_down_cnt.sv | 37 +++
 rtl/seq_pattern_gen.sv | 171 +++++++++++++++++
 tb/tb_seq_pattern_gen.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the serial pattern generator and its detector bench.
// Latency: n/a (types only); backpressure: n/a.
package seq_gen_pkg;

  localparam int DEF_MAX_LEN = 16;
  localparam int DEF_REP_W   = 8;
  localparam int DEF_GAP_W   = 4;

  localparam logic [3:0] SEQ_1011 = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/seq_down_cnt.sv
// Loadable down-counter; exposes its next value and a zero flag on the current value.
// Latency: load/decrement visible one clk later; no backpressure.
module seq_down_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_nxt,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Load wins over decrement so a reload on the last count needs no extra cycle.
  always_comb begin
    o_nxt = r_cnt;
    if (i_load) begin
      o_nxt = i_load_val;
    end else if (i_dec) begin
      o_nxt = r_cnt - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= o_nxt;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial MSB-first pattern generator with repetitions and idle gaps between them.
// Latency 1 from the start edge to the first bit; no backpressure, start ignored while running.
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int REP_W   = DEF_REP_W,
  parameter int GAP_W   = DEF_GAP_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic [REP_W-1:0]   reps,
  input  logic [GAP_W-1:0]   gap,
  output logic               out,
  output logic               out_valid,
  output logic               busy,
  output logic               done
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_t r_state;
  state_t w_state_nxt;

  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic [GAP_W-1:0]   r_gap;

  logic               w_accept;
  logic [LEN_W-1:0]   w_len_clamp;
  logic [IDX_W-1:0]   w_idx_reload;
  logic [MAX_LEN-1:0] w_pat_nxt;

  logic               w_idx_load, w_idx_dec, w_idx_zero;
  logic [IDX_W-1:0]   w_idx_val, w_idx_nxt;
  logic               w_rep_load, w_rep_dec, w_rep_zero;
  logic [REP_W-1:0]   w_rep_val, w_rep_nxt;
  logic               w_gap_load, w_gap_dec, w_gap_zero;
  logic [GAP_W-1:0]   w_gap_val, w_gap_nxt;
  logic               w_unused_nxt;

  assign w_len_clamp  = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
  assign w_idx_reload = IDX_W'(r_len - LEN_W'(1));
  assign w_pat_nxt    = w_accept ? pattern : r_pat;
  assign w_unused_nxt = ^{w_rep_nxt, w_gap_nxt};

  // Rep and gap counters hold "remaining after this one", so the zero flag marks the last.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_idx_load  = 1'b0;
    w_idx_val   = '0;
    w_idx_dec   = 1'b0;
    w_rep_load  = 1'b0;
    w_rep_val   = '0;
    w_rep_dec   = 1'b0;
    w_gap_load  = 1'b0;
    w_gap_val   = '0;
    w_gap_dec   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && (len != '0)) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_SEND;
          w_idx_load  = 1'b1;
          w_idx_val   = IDX_W'(w_len_clamp - LEN_W'(1));
          w_rep_load  = 1'b1;
          w_rep_val   = (reps == '0) ? '0 : reps - REP_W'(1);
        end
      end
      ST_SEND: begin
        if (!w_idx_zero) begin
          w_idx_dec = 1'b1;
        end else if (w_rep_zero) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_rep_dec = 1'b1;
          if (r_gap != '0) begin
            w_state_nxt = ST_GAP;
            w_gap_load  = 1'b1;
            w_gap_val   = r_gap - GAP_W'(1);
          end else begin
            w_idx_load = 1'b1;
            w_idx_val  = w_idx_reload;
          end
        end
      end
      ST_GAP: begin
        if (w_gap_zero) begin
          w_state_nxt = ST_SEND;
          w_idx_load  = 1'b1;
          w_idx_val   = w_idx_reload;
        end else begin
          w_gap_dec = 1'b1;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pat <= '0;
      r_len <= '0;
      r_gap <= '0;
    end else if (w_accept) begin
      r_pat <= pattern;
      r_len <= w_len_clamp;
      r_gap <= gap;
    end
  end

  // Outputs are flopped from next-state values so the first bit lands right after the start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      out       <= (w_state_nxt == ST_SEND) && w_pat_nxt[w_idx_nxt];
      out_valid <= (w_state_nxt == ST_SEND);
      busy      <= (w_state_nxt == ST_SEND) || (w_state_nxt == ST_GAP);
      done      <= (w_state_nxt == ST_DONE);
    end
  end

  seq_down_cnt #(.W(IDX_W)) u_idx_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_idx_load),
    .i_load_val (w_idx_val),
    .i_dec      (w_idx_dec),
    .o_nxt      (w_idx_nxt),
    .o_zero     (w_idx_zero)
  );

  seq_down_cnt #(.W(REP_W)) u_rep_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_rep_load),
    .i_load_val (w_rep_val),
    .i_dec      (w_rep_dec),
    .o_nxt      (w_rep_nxt),
    .o_zero     (w_rep_zero)
  );

  seq_down_cnt #(.W(GAP_W)) u_gap_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_gap_load),
    .i_load_val (w_gap_val),
    .i_dec      (w_gap_dec),
    .o_nxt      (w_gap_nxt),
    .o_zero     (w_gap_zero)
  );

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: directed edge cases plus random runs against a queue-based stream model.
module tb_seq_pattern_gen;
  import seq_gen_pkg::*;

  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;
  localparam int REP_W   = 8;
  localparam int GAP_W   = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic [REP_W-1:0]   reps;
  logic [GAP_W-1:0]   gap;
  logic               out, out_valid, busy, done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_pattern_gen #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W),
    .REP_W   (REP_W),
    .GAP_W   (GAP_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pattern   (pattern),
    .len       (len),
    .reps      (reps),
    .gap       (gap),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Outputs packed as {done, busy, out_valid, out}.
  task automatic chk_outs(input string tag, input logic [3:0] exp);
    chk(tag, {28'b0, done, busy, out_valid, out}, {28'b0, exp});
  endtask

  // Model: expand the request into the per-cycle stream, then compare cycle by cycle.
  task automatic run_txn(input logic [15:0] p, input int l, input int r, input int g,
                         input bit perturb, input string tag);
    logic [1:0] q[$];
    logic [3:0] exp;
    int lc, n, ncyc;
    lc = (l > MAX_LEN) ? MAX_LEN : l;
    n  = (r == 0) ? 1 : r;
    for (int k = 0; k < n; k++) begin
      for (int i = lc - 1; i >= 0; i--) q.push_back({1'b1, p[i]});
      if (k < n - 1) for (int j = 0; j < g; j++) q.push_back(2'b00);
    end
    ncyc = q.size() + 1;
    @(negedge clk);
    pattern = p;
    len     = l[LEN_W-1:0];
    reps    = r[REP_W-1:0];
    gap     = g[GAP_W-1:0];
    start   = 1'b1;
    for (int c = 1; c <= ncyc + 1; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c < ncyc)       exp = {2'b01, q[c-1]};
      else if (c == ncyc) exp = 4'b1000;
      else                exp = 4'b0000;
      chk_outs($sformatf("%s c%0d", tag, c), exp);
      if (perturb && c <= ncyc) begin
        start   = 1'($urandom_range(0, 1));
        pattern = 16'($urandom);
        len     = 5'($urandom_range(0, 20));
        reps    = 8'($urandom_range(0, 5));
        gap     = 4'($urandom_range(0, 15));
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    pattern = '0;
    len     = '0;
    reps    = '0;
    gap     = '0;
    @(negedge clk);
    @(negedge clk);
    chk_outs("reset", 4'b0000);
    rst = 1'b0;
    @(negedge clk);
    chk_outs("post_reset", 4'b0000);

    run_txn({12'h0, SEQ_1011}, 4, 1, 0, 1'b0, "basic1011");
    run_txn(16'h000B, 4, 2, 0, 1'b0, "b2b");
    run_txn(16'h000B, 4, 3, 2, 1'b0, "gap2");
    run_txn(16'hA5C3, 20, 1, 0, 1'b0, "len20");
    run_txn(16'h000B, 4, 0, 3, 1'b0, "reps0");
    run_txn(16'h0001, 1, 3, 1, 1'b0, "len1");
    run_txn(16'h000B, 4, 1, 0, 1'b1, "busy_start");

    // len=0 must be ignored entirely.
    @(negedge clk);
    pattern = 16'hFFFF;
    len     = '0;
    reps    = 8'd2;
    start   = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      chk_outs($sformatf("len0 c%0d", c), 4'b0000);
    end

    // Asynchronous reset during the third bit of 1011.
    @(negedge clk);
    pattern = 16'h000B;
    len     = 5'd4;
    reps    = 8'd1;
    gap     = '0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_outs("rst_mid bit3", 4'b0111);
    #1 rst = 1'b1;
    #1 chk_outs("rst_mid async", 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk_outs($sformatf("rst_mid idle c%0d", c), 4'b0000);
    end
    run_txn(16'h000B, 4, 1, 0, 1'b0, "after_rst");

    for (int t = 0; t < 30; t++) begin
      run_txn(16'($urandom), int'($urandom_range(1, 20)), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", t));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
